// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor / BTB.
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    // Tag and target fields are sized for the widest supported PC; unused high bits stay zero.
    localparam int BP_MAX_W = 64;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bp_cnt_e;

    typedef struct packed {
        logic                valid;
        logic [BP_MAX_W-1:0] tag;
        logic [BP_MAX_W-1:0] target;
        bp_cnt_e             cnt;
    } btb_entry_t;

    function automatic bp_cnt_e sat_update(input bp_cnt_e cnt, input logic taken);
        if (taken) begin
            return (cnt == STRONG_T) ? STRONG_T : bp_cnt_e'(cnt + 2'd1);
        end
        return (cnt == STRONG_NT) ? STRONG_NT : bp_cnt_e'(cnt - 2'd1);
    endfunction

endpackage

// File: rtl/bp_btb_array.sv
// BTB/PHT entry storage: async reset, one combinational read port, one
// synchronous read-modify-write port that applies a resolved branch outcome.
module bp_btb_array
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX-1:0]      rd_idx,
    output btb_entry_t          rd_entry,
    input  logic                wr_en,
    input  logic [IDX-1:0]      wr_idx,
    input  logic [BP_MAX_W-1:0] wr_tag,
    input  logic                wr_taken,
    input  logic [BP_MAX_W-1:0] wr_target,
    input  logic                wr_is_jal,
    input  logic                wr_is_jalr
);

    btb_entry_t mem [ENTRIES];
    btb_entry_t cur_entry;
    btb_entry_t nxt_entry;
    logic       tag_hit;

    assign rd_entry = mem[rd_idx];

    always_comb begin
        cur_entry = mem[wr_idx];
        nxt_entry = cur_entry;
        tag_hit   = cur_entry.valid && (cur_entry.tag == wr_tag);
        // JALR targets are data dependent, so they never allocate or overwrite a target.
        if (tag_hit) begin
            nxt_entry.cnt = sat_update(cur_entry.cnt, wr_taken);
            if (wr_taken && !wr_is_jalr) begin
                nxt_entry.target = wr_target;
            end
        end else if (wr_taken && !wr_is_jalr) begin
            nxt_entry.valid  = 1'b1;
            nxt_entry.tag    = wr_tag;
            nxt_entry.target = wr_target;
            nxt_entry.cnt    = wr_is_jal ? STRONG_T : WEAK_T;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};
            end
        end else if (wr_en) begin
            mem[wr_idx] <= nxt_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor + BTB: zero-latency fetch lookup, E-stage resolve,
// non-speculative update and prediction performance counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int ENTRIES       = 16,
    parameter int MODE          = BP_MODE_BIMODAL,
    parameter int HIST_BITS     = 4,
    parameter int CNT_WIDTH     = 32,
    localparam int IDX = $clog2(ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] f_pc,
    output logic                     f_pred_taken,
    output logic [ADDRESS_WIDTH-1:0] f_pred_target,
    output logic [IDX-1:0]           f_pred_idx,
    input  logic                     e_update,
    input  logic [ADDRESS_WIDTH-1:0] e_pc,
    input  logic                     e_pred_taken,
    input  logic [ADDRESS_WIDTH-1:0] e_pred_target,
    input  logic [IDX-1:0]           e_pred_idx,
    input  logic                     e_taken,
    input  logic [ADDRESS_WIDTH-1:0] e_target,
    input  logic                     e_is_jal,
    input  logic                     e_is_jalr,
    output logic                     e_mispredict,
    output logic [ADDRESS_WIDTH-1:0] e_redirect_pc,
    output logic [CNT_WIDTH-1:0]     predcount,
    output logic [CNT_WIDTH-1:0]     mispredcount
);

    localparam int HIST_W = (MODE == BP_MODE_GSHARE) ? HIST_BITS : 1;

    logic [HIST_W-1:0] ghr;
    logic [IDX-1:0]    f_idx;
    btb_entry_t        rd_entry;
    logic              hit;
    logic              unused_target_bits;

    // History is only shifted at resolve, so lookups never see speculative outcomes.
    generate
        if (MODE == BP_MODE_GSHARE) begin : g_gshare
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ghr <= '0;
                end else if (e_update) begin
                    ghr <= HIST_W'({ghr, e_taken});
                end
            end
        end else begin : g_bimodal
            assign ghr = '0;
        end
    endgenerate

    assign f_idx      = f_pc[IDX+1:2] ^ IDX'(ghr);
    assign f_pred_idx = f_idx;

    assign hit           = rd_entry.valid && (rd_entry.tag == BP_MAX_W'(f_pc[ADDRESS_WIDTH-1:IDX+2]));
    assign f_pred_taken  = hit && rd_entry.cnt[1];
    assign f_pred_target = f_pred_taken ? rd_entry.target[ADDRESS_WIDTH-1:0]
                                        : f_pc + ADDRESS_WIDTH'(4);
    assign unused_target_bits = ^rd_entry.target;

    assign e_mispredict  = e_update && ((e_taken != e_pred_taken) ||
                                        (e_taken && (e_target != e_pred_target)));
    assign e_redirect_pc = e_taken ? e_target : e_pc + ADDRESS_WIDTH'(4);

    bp_btb_array #(
        .ENTRIES(ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (f_idx),
        .rd_entry  (rd_entry),
        .wr_en     (e_update),
        .wr_idx    (e_pred_idx),
        .wr_tag    (BP_MAX_W'(e_pc[ADDRESS_WIDTH-1:IDX+2])),
        .wr_taken  (e_taken),
        .wr_target (BP_MAX_W'(e_target)),
        .wr_is_jal (e_is_jal),
        .wr_is_jalr(e_is_jalr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            predcount    <= '0;
            mispredcount <= '0;
        end else if (e_update) begin
            predcount <= predcount + CNT_WIDTH'(1);
            if (e_mispredict) begin
                mispredcount <= mispredcount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic on a
// bimodal instance checked against a table model, and a directed gshare instance.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;
    logic [3:0]  f_pred_idx;
    logic        e_update;
    logic [31:0] e_pc;
    logic        e_pred_taken;
    logic [31:0] e_pred_target;
    logic [3:0]  e_pred_idx;
    logic        e_taken;
    logic [31:0] e_target;
    logic        e_is_jal;
    logic        e_is_jalr;
    logic        e_mispredict;
    logic [31:0] e_redirect_pc;
    logic [31:0] predcount;
    logic [31:0] mispredcount;

    logic        g_rst;
    logic [31:0] g_f_pc;
    logic        g_f_pred_taken;
    logic [31:0] g_f_pred_target;
    logic [3:0]  g_f_pred_idx;
    logic        g_e_update;
    logic [31:0] g_e_pc;
    logic        g_e_pred_taken;
    logic [31:0] g_e_pred_target;
    logic [3:0]  g_e_pred_idx;
    logic        g_e_taken;
    logic [31:0] g_e_target;
    logic        g_e_is_jal;
    logic        g_e_is_jalr;
    logic        g_e_mispredict;
    logic [31:0] g_e_redirect_pc;
    logic [31:0] g_predcount;
    logic [31:0] g_mispredcount;

    branch_predictor #(.ADDRESS_WIDTH(32), .ENTRIES(16), .MODE(0), .HIST_BITS(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .f_pred_target(f_pred_target), .f_pred_idx(f_pred_idx), .e_update(e_update),
        .e_pc(e_pc), .e_pred_taken(e_pred_taken), .e_pred_target(e_pred_target),
        .e_pred_idx(e_pred_idx), .e_taken(e_taken), .e_target(e_target),
        .e_is_jal(e_is_jal), .e_is_jalr(e_is_jalr), .e_mispredict(e_mispredict),
        .e_redirect_pc(e_redirect_pc), .predcount(predcount), .mispredcount(mispredcount)
    );

    branch_predictor #(.ADDRESS_WIDTH(32), .ENTRIES(16), .MODE(1), .HIST_BITS(4), .CNT_WIDTH(32)) dut_g (
        .clk(clk), .rst(g_rst), .f_pc(g_f_pc), .f_pred_taken(g_f_pred_taken),
        .f_pred_target(g_f_pred_target), .f_pred_idx(g_f_pred_idx), .e_update(g_e_update),
        .e_pc(g_e_pc), .e_pred_taken(g_e_pred_taken), .e_pred_target(g_e_pred_target),
        .e_pred_idx(g_e_pred_idx), .e_taken(g_e_taken), .e_target(g_e_target),
        .e_is_jal(g_e_is_jal), .e_is_jalr(g_e_is_jalr), .e_mispredict(g_e_mispredict),
        .e_redirect_pc(g_e_redirect_pc), .predcount(g_predcount), .mispredcount(g_mispredcount)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [3:0]  idx;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] pcnt;
        logic [31:0] mcnt;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];
    exp_t          cur_exp;
    int            n_checks = 0;
    int            n_pass   = 0;

    // Table model: one slot per index, counters as plain integers 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    logic [31:0] m_pred;
    logic [31:0] m_misp;
    int          g_hist;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_cnt[i]   = 1;
        end
        m_pred = '0;
        m_misp = '0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output logic tk,
                                         output logic [31:0] tg, output logic [3:0] ix);
        int i;
        i  = int'((pc / 4) % 16);
        ix = 4'(i);
        tk = m_valid[i] && (m_tag[i] == pc / 64) && (m_cnt[i] >= 2);
        tg = tk ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void model_update(input logic [3:0] ix, input logic [31:0] pc, input logic tk,
                                         input logic [31:0] tg, input logic jal, input logic jalr);
        int i;
        i = int'(ix);
        if (m_valid[i] && m_tag[i] == pc / 64) begin
            if (tk) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
            else    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
            if (tk && !jalr) m_tgt[i] = tg;
        end else if (tk && !jalr) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc / 64;
            m_tgt[i]   = tg;
            m_cnt[i]   = jal ? 3 : 2;
        end
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle shortly after the rising edge and queues what the outputs must show.
    task automatic drive(input logic rst_v, input logic [31:0] fpc, input logic upd,
                         input logic [31:0] epc, input logic ept, input logic [31:0] eptgt,
                         input logic [3:0] epidx, input logic et, input logic [31:0] etgt,
                         input logic jal, input logic jalr);
        exp_t x;
        @(posedge clk);
        #1;
        rst = rst_v; f_pc = fpc; e_update = upd; e_pc = epc; e_pred_taken = ept;
        e_pred_target = eptgt; e_pred_idx = epidx; e_taken = et; e_target = etgt;
        e_is_jal = jal; e_is_jalr = jalr;
        if (rst_v) model_reset();
        model_lookup(fpc, x.taken, x.target, x.idx);
        x.mis   = upd && ((et != ept) || (et && etgt != eptgt));
        x.redir = et ? etgt : epc + 32'd4;
        x.pcnt  = m_pred;
        x.mcnt  = m_misp;
        exp_q.push_back(x);
        if (upd && !rst_v) begin
            model_update(epidx, epc, et, etgt, jal, jalr);
            m_pred = m_pred + 32'd1;
            if (x.mis) m_misp = m_misp + 32'd1;
        end
    endtask

    task automatic idle(input logic [31:0] fpc);
        drive(1'b0, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic g_step(input logic upd, input logic [31:0] epc, input logic ept,
                          input logic [31:0] eptgt, input logic [3:0] epidx,
                          input logic et, input logic [31:0] etgt);
        @(posedge clk);
        #1;
        g_e_update = upd; g_e_pc = epc; g_e_pred_taken = ept; g_e_pred_target = eptgt;
        g_e_pred_idx = epidx; g_e_taken = et; g_e_target = etgt;
        if (upd) g_hist = ((g_hist << 1) | int'(et)) % 16;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur_exp = exp_t'(exp_q.pop_front());
            check("f_pred_taken",  32'(f_pred_taken), 32'(cur_exp.taken));
            check("f_pred_target", f_pred_target,     cur_exp.target);
            check("f_pred_idx",    32'(f_pred_idx),   32'(cur_exp.idx));
            check("e_mispredict",  32'(e_mispredict), 32'(cur_exp.mis));
            check("e_redirect_pc", e_redirect_pc,     cur_exp.redir);
            check("predcount",     predcount,         cur_exp.pcnt);
            check("mispredcount",  mispredcount,      cur_exp.mcnt);
        end
    end

    // ---------------- stimulus ----------------
    logic        r_tk;
    logic [31:0] r_tg;
    logic [3:0]  r_ix;
    logic [31:0] r_epc;
    logic        r_et;
    logic [31:0] r_etgt;
    logic        r_jal;
    logic        r_jalr;

    initial begin
        rst = 1'b1; f_pc = '0; e_update = 1'b0; e_pc = '0; e_pred_taken = 1'b0;
        e_pred_target = '0; e_pred_idx = '0; e_taken = 1'b0; e_target = '0;
        e_is_jal = 1'b0; e_is_jalr = 1'b0;
        g_rst = 1'b1; g_f_pc = '0; g_e_update = 1'b0; g_e_pc = '0; g_e_pred_taken = 1'b0;
        g_e_pred_target = '0; g_e_pred_idx = '0; g_e_taken = 1'b0; g_e_target = '0;
        g_e_is_jal = 1'b0; g_e_is_jalr = 1'b0; g_hist = 0;
        model_reset();

        // Reset state
        drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(32'h40);
        mid();
        check("reset_taken",  32'(f_pred_taken), 32'h0);
        check("reset_target", f_pred_target, 32'h44);
        check("reset_pcnt",   predcount, 32'h0);
        check("reset_mcnt",   mispredcount, 32'h0);

        // First taken resolve allocates with a weakly-taken counter
        drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h44, 4'h0, 1'b1, 32'h20, 1'b0, 1'b0);
        mid();
        check("alloc_mispredict", 32'(e_mispredict), 32'h1);
        check("alloc_redirect",   e_redirect_pc, 32'h20);
        idle(32'h40);
        mid();
        check("alloc_taken",  32'(f_pred_taken), 32'h1);
        check("alloc_target", f_pred_target, 32'h20);
        check("alloc_mcnt",   mispredcount, 32'h1);

        // Counter walks down to 00 and one taken only brings it back to 01
        drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h44, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        idle(32'h40);
        mid();
        check("sat_low_taken", 32'(f_pred_taken), 32'h0);
        drive(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 32'h44, 4'h0, 1'b1, 32'h20, 1'b0, 1'b0);
        idle(32'h40);
        mid();
        check("weak_nt_taken",  32'(f_pred_taken), 32'h0);
        check("weak_nt_target", f_pred_target, 32'h44);

        // JAL at an aliasing PC replaces the entry
        drive(1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h84, 4'h0, 1'b1, 32'h100, 1'b1, 1'b0);
        idle(32'h40);
        mid();
        check("alias_old_taken", 32'(f_pred_taken), 32'h0);
        idle(32'h80);
        mid();
        check("jal_taken",  32'(f_pred_taken), 32'h1);
        check("jal_target", f_pred_target, 32'h100);

        // JALR miss never allocates
        drive(1'b0, 32'h44, 1'b1, 32'h44, 1'b0, 32'h48, 4'h1, 1'b1, 32'h200, 1'b0, 1'b1);
        mid();
        check("jalr_mispredict", 32'(e_mispredict), 32'h1);
        check("jalr_redirect",   e_redirect_pc, 32'h200);
        idle(32'h44);
        mid();
        check("jalr_no_alloc", 32'(f_pred_taken), 32'h0);
        check("dir_pcnt",      predcount, 32'd6);
        check("dir_mcnt",      mispredcount, 32'd5);

        // Randomized traffic over a small aliasing PC pool, with occasional resets
        for (int n = 0; n < 800; n++) begin
            r_epc = 32'($urandom_range(0, 63)) * 32'd4;
            model_lookup(r_epc, r_tk, r_tg, r_ix);
            if ($urandom_range(0, 4) == 0) begin
                r_tk = 1'($urandom_range(0, 1));
                r_tg = 32'($urandom_range(0, 15)) * 32'h10;
                r_ix = 4'($urandom_range(0, 15));
            end
            r_jal  = ($urandom_range(0, 7) == 0);
            r_jalr = !r_jal && ($urandom_range(0, 7) == 0);
            r_et   = r_jal || r_jalr || ($urandom_range(0, 1) == 1);
            r_etgt = ($urandom_range(0, 2) == 0) ? r_tg : 32'($urandom_range(0, 15)) * 32'h10;
            drive(1'($urandom_range(0, 99) == 0), 32'($urandom_range(0, 63)) * 32'd4,
                  1'($urandom_range(0, 3) != 0), r_epc, r_tk, r_tg, r_ix,
                  r_et, r_etgt, r_jal, r_jalr);
        end
        idle(32'h0);
        mid();

        // Gshare instance: history taken, taken, not-taken then reset
        g_step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        g_rst = 1'b0;
        g_step(1'b1, 32'h40, 1'b0, 32'h44, 4'h0, 1'b1, 32'h20);
        g_step(1'b1, 32'h40, 1'b1, 32'h20, 4'h1, 1'b1, 32'h20);
        g_step(1'b1, 32'h40, 1'b0, 32'h44, 4'h3, 1'b0, 32'h0);
        g_step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
        g_f_pc = 32'h40;
        mid();
        check("g_idx_lit",   32'(g_f_pred_idx), 32'h6);
        check("g_idx_model", 32'(g_f_pred_idx), 32'(((32'h40 / 4) % 16) ^ g_hist));
        check("g_pcnt",      g_predcount, 32'd3);
        check("g_mcnt",      g_mispredcount, 32'd1);
        g_f_pc = 32'h58;
        #1;
        check("g_hash_hit_taken",  32'(g_f_pred_taken), 32'h1);
        check("g_hash_hit_target", g_f_pred_target, 32'h20);
        g_rst = 1'b1;
        g_hist = 0;
        #1;
        check("g_rst_idx58",   32'(g_f_pred_idx), 32'h6);
        check("g_rst_taken58", 32'(g_f_pred_taken), 32'h0);
        g_f_pc = 32'h40;
        #1;
        check("g_rst_idx40",    32'(g_f_pred_idx), 32'h0);
        check("g_rst_taken40",  32'(g_f_pred_taken), 32'h0);
        check("g_rst_target40", g_f_pred_target, 32'h44);
        check("g_rst_pcnt",     g_predcount, 32'h0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
